// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard/forwarding unit with a single-entry MDU scoreboard
// Forward select, load-use and MDU RAW/WAW/structural stalls, timed MDU writeback, stall counter.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int NSTAGE  = 2,
  parameter int SW      = 2,
  parameter int MDU_LAT = 4,
  parameter int CW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        id_rs,
  input  logic [AW-1:0]        id_rt,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic                 id_wen,
  input  logic [AW-1:0]        id_waddr,
  input  logic                 id_mdu_issue,
  input  logic                 id_flush,
  input  logic [NSTAGE-1:0]    st_wen,
  input  logic [NSTAGE*AW-1:0] st_waddr,
  input  logic [NSTAGE-1:0]    st_load,
  input  logic                 mdu_kill,
  output logic                 stall,
  output logic [SW-1:0]        fwd_a,
  output logic [SW-1:0]        fwd_b,
  output logic                 mdu_busy,
  output logic                 mdu_wb_valid,
  output logic [AW-1:0]        mdu_wb_addr,
  output logic [CW-1:0]        stall_cnt
);

  logic          valid_q, valid_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic lu_a, lu_b, raw_hz, waw_hz, struct_hz, issue;

  // Stages scanned oldest to youngest so the youngest matching stage is the last writer.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (st_wen[k] && (st_waddr[k*AW +: AW] == id_rs) && (id_rs != '0)) begin
        if (k == 0 && st_load[0]) begin
          fwd_a = '0;
          lu_a  = 1'b1;
        end else begin
          fwd_a = SW'(k + 1);
          lu_a  = 1'b0;
        end
      end
      if (st_wen[k] && (st_waddr[k*AW +: AW] == id_rt) && (id_rt != '0)) begin
        if (k == 0 && st_load[0]) begin
          fwd_b = '0;
          lu_b  = 1'b1;
        end else begin
          fwd_b = SW'(k + 1);
          lu_b  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    raw_hz    = valid_q && (paddr_q != '0) &&
                ((id_rs_used && (id_rs == paddr_q)) || (id_rt_used && (id_rt == paddr_q)));
    waw_hz    = valid_q && id_wen && (id_waddr == paddr_q) && (id_waddr != '0);
    struct_hz = valid_q && id_mdu_issue;
    stall     = !id_flush && ((id_rs_used && lu_a) || (id_rt_used && lu_b) ||
                              raw_hz || waw_hz || struct_hz);
    issue     = id_mdu_issue && !stall && !id_flush && !mdu_kill;
  end

  // Entry stays valid through the writeback cycle (cnt_q==0) and retires at its end.
  always_comb begin
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    paddr_d    = paddr_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    if (mdu_kill) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (issue) begin
      valid_d = 1'b1;
      cnt_d   = 4'(MDU_LAT - 1);
      paddr_d = id_waddr;
    end else if (valid_q) begin
      if (cnt_q == '0) begin
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = paddr_q;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      paddr_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mdu_busy     = valid_q;
  assign mdu_wb_valid = wb_valid_q;
  assign mdu_wb_addr  = wb_addr_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_waddr;
  logic        id_rs_used, id_rt_used, id_wen, id_mdu_issue, id_flush, mdu_kill;
  logic [1:0]  st_wen, st_load;
  logic [9:0]  st_waddr;

  logic        stall, busy, wbv;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  wba;
  logic [31:0] scnt;

  logic        stall4, busy4, wbv4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [4:0]  wba4;
  logic [3:0]  scnt4;

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(5), .NSTAGE(2), .SW(2), .MDU_LAT(4), .CW(32)) u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_wen(id_wen), .id_waddr(id_waddr), .id_mdu_issue(id_mdu_issue),
    .id_flush(id_flush), .st_wen(st_wen), .st_waddr(st_waddr), .st_load(st_load),
    .mdu_kill(mdu_kill), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .mdu_busy(busy),
    .mdu_wb_valid(wbv), .mdu_wb_addr(wba), .stall_cnt(scnt)
  );

  hazard_scoreboard #(.AW(5), .NSTAGE(2), .SW(2), .MDU_LAT(4), .CW(4)) u_cw4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_wen(id_wen), .id_waddr(id_waddr), .id_mdu_issue(id_mdu_issue),
    .id_flush(id_flush), .st_wen(st_wen), .st_waddr(st_waddr), .st_load(st_load),
    .mdu_kill(mdu_kill), .stall(stall4), .fwd_a(fwd_a4), .fwd_b(fwd_b4), .mdu_busy(busy4),
    .mdu_wb_valid(wbv4), .mdu_wb_addr(wba4), .stall_cnt(scnt4)
  );

  typedef struct {
    string nm;
    logic  stall;
    int    fa;
    int    fb;
    logic  busy;
    logic  wbv;
    int    wba;
    int    cnt;
    int    cnt4;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;

  function automatic void chk(string nm, string fld, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk(me.nm, "stall", int'(stall), int'(me.stall));
      chk(me.nm, "fwd_a", int'(fwd_a), me.fa);
      chk(me.nm, "fwd_b", int'(fwd_b), me.fb);
      chk(me.nm, "mdu_busy", int'(busy), int'(me.busy));
      chk(me.nm, "mdu_wb_valid", int'(wbv), int'(me.wbv));
      if (me.wba >= 0) begin
        chk(me.nm, "mdu_wb_addr", int'(wba), me.wba);
        chk(me.nm, "cw4_wb_addr", int'(wba4), me.wba);
      end
      chk(me.nm, "stall_cnt", int'(scnt), me.cnt);
      chk(me.nm, "stall_cnt_cw4", int'(scnt4), me.cnt4);
      chk(me.nm, "cw4_outs", int'({stall4, fwd_a4, fwd_b4, busy4, wbv4}),
          int'({me.stall, 2'(me.fa), 2'(me.fb), me.busy, me.wbv}));
    end
  end

  task automatic idle();
    id_rs = '0; id_rt = '0; id_waddr = '0;
    id_rs_used = 0; id_rt_used = 0; id_wen = 0; id_mdu_issue = 0; id_flush = 0; mdu_kill = 0;
    st_wen = '0; st_load = '0; st_waddr = '0;
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic step(input string nm, input logic es, input int efa, input int efb,
                      input logic eb, input logic ewv, input int ewa);
    exp_t e;
    e.nm = nm; e.stall = es; e.fa = efa; e.fb = efb; e.busy = eb; e.wbv = ewv; e.wba = ewa;
    e.cnt = exp_cnt;
    e.cnt4 = (exp_cnt > 15) ? 15 : exp_cnt;
    sb.push_back(e);
    if (rst) exp_cnt = 0;
    else if (es) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic mdu_issue(input logic [4:0] dst);
    idle();
    id_mdu_issue = 1; id_wen = 1; id_waddr = dst;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    step("reset", 0, 0, 0, 0, 0, 0);
    rst = 0;

    idle(); st_wen = 2'b11; st_waddr = {5'd8, 5'd8}; id_rs = 8; id_rs_used = 1;
    step("alu_two_src", 0, 1, 0, 0, 0, -1);
    st_wen = 2'b10;
    step("alu_mem_only", 0, 2, 0, 0, 0, -1);
    st_wen = 2'b11; id_rt = 8;
    step("alu_both_ops", 0, 1, 1, 0, 0, -1);
    st_load = 2'b10;
    step("alu_young_wins", 0, 1, 1, 0, 0, -1);

    idle(); st_wen = 2'b01; st_load = 2'b01; st_waddr = {5'd0, 5'd9}; id_rt = 9; id_rt_used = 1;
    step("load_use", 1, 0, 0, 0, 0, -1);
    id_rt_used = 0;
    step("load_unused", 0, 0, 0, 0, 0, -1);
    id_rt_used = 1; id_flush = 1;
    step("load_use_flush", 0, 0, 0, 0, 0, -1);
    idle(); st_wen = 2'b10; st_load = 2'b10; st_waddr = {5'd9, 5'd0}; id_rt = 9; id_rt_used = 1;
    step("load_mem", 0, 0, 2, 0, 0, -1);
    idle(); st_wen = 2'b11; st_load = 2'b11; id_rs_used = 1; id_rt_used = 1;
    step("r0_write", 0, 0, 0, 0, 0, -1);

    mdu_issue(10);
    step("mdu_issue", 0, 0, 0, 0, 0, -1);
    idle(); id_rs = 10; id_rs_used = 1;
    for (int c = 1; c <= 4; c++)
      step($sformatf("mdu_raw_c%0d", c), 1, 0, 0, 1, c == 4, (c == 4) ? 10 : -1);
    step("mdu_raw_release", 0, 0, 0, 0, 0, -1);

    mdu_issue(10);
    step("st_issue", 0, 0, 0, 0, 0, -1);
    mdu_issue(11);
    for (int c = 1; c <= 4; c++)
      step($sformatf("struct_c%0d", c), 1, 0, 0, 1, c == 4, (c == 4) ? 10 : -1);
    step("struct_accept", 0, 0, 0, 0, 0, -1);
    idle(); id_wen = 1; id_waddr = 11;
    step("waw", 1, 0, 0, 1, 0, -1);
    id_flush = 1;
    step("waw_flush", 0, 0, 0, 1, 0, -1);
    mdu_issue(12); id_flush = 1;
    step("flush_issue", 0, 0, 0, 1, 0, -1);
    idle(); id_rt = 11; id_rt_used = 1;
    step("raw_rt_wb", 1, 0, 0, 1, 1, 11);
    idle();
    step("flushed_not_taken", 0, 0, 0, 0, 0, -1);

    mdu_issue(0);
    step("z_issue", 0, 0, 0, 0, 0, -1);
    idle(); id_rs_used = 1; id_rt_used = 1; id_wen = 1;
    for (int c = 1; c <= 3; c++)
      step($sformatf("z_nohaz_c%0d", c), 0, 0, 0, 1, 0, -1);
    step("z_wb", 0, 0, 0, 1, 1, 0);
    step("z_done", 0, 0, 0, 0, 0, -1);

    mdu_issue(12);
    step("k_issue", 0, 0, 0, 0, 0, -1);
    idle();
    step("k_c1", 0, 0, 0, 1, 0, -1);
    mdu_kill = 1;
    step("k_c2", 0, 0, 0, 1, 0, -1);
    idle();
    for (int c = 3; c <= 5; c++)
      step($sformatf("k_after_c%0d", c), 0, 0, 0, 0, 0, -1);

    mdu_issue(15);
    step("kwb_issue", 0, 0, 0, 0, 0, -1);
    idle();
    for (int c = 1; c <= 3; c++)
      step($sformatf("kwb_c%0d", c), 0, 0, 0, 1, 0, -1);
    mdu_kill = 1;
    step("kwb_pulse", 0, 0, 0, 1, 1, 15);
    idle();
    step("kwb_done", 0, 0, 0, 0, 0, -1);

    mdu_issue(13);
    step("r_issue", 0, 0, 0, 0, 0, -1);
    idle();
    step("r_c1", 0, 0, 0, 1, 0, -1);
    rst = 1;
    step("r_c2", 0, 0, 0, 1, 0, -1);
    rst = 0;
    step("r_c3", 0, 0, 0, 0, 0, 0);
    step("r_c4", 0, 0, 0, 0, 0, 0);
    step("r_c5", 0, 0, 0, 0, 0, 0);

    mdu_issue(14); mdu_kill = 1;
    step("ki_issue", 0, 0, 0, 0, 0, -1);
    idle(); id_rs = 14; id_rs_used = 1;
    step("ki_not_taken", 0, 0, 0, 0, 0, -1);

    idle(); st_wen = 2'b01; st_load = 2'b01; st_waddr = {5'd0, 5'd9}; id_rt = 9; id_rt_used = 1;
    for (int i = 0; i < 20; i++)
      step($sformatf("cnt_%0d", i), 1, 0, 0, 0, 0, -1);
    idle();
    step("cnt_end", 0, 0, 0, 0, 0, -1);
    step("cnt_hold", 0, 0, 0, 0, 0, -1);

    @(negedge clk);
    #1;
    chk("end", "queue_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
